// File: rtl/decoder_pkg.sv
// Shared types and encodings for the instruction decode stage.
// Instruction layout: [INST_W-1 -: 4] opcode, [INST_W-5:0] payload.
// Inside the payload: reg field at the top, data immediate at the bottom,
// and the whole payload is the address immediate.
package decoder_pkg;

    localparam int OPC_W      = 4;
    localparam int REG_ADDR_W = 4;

    localparam logic [OPC_W-1:0] OPCODE_NOP     = 4'h0;
    localparam logic [OPC_W-1:0] OPCODE_ALU_REG = 4'h1;
    localparam logic [OPC_W-1:0] OPCODE_ALU_IMM = 4'h2;
    localparam logic [OPC_W-1:0] OPCODE_SET     = 4'h3;
    localparam logic [OPC_W-1:0] OPCODE_LOAD    = 4'h4;
    localparam logic [OPC_W-1:0] OPCODE_STORE   = 4'h5;
    localparam logic [OPC_W-1:0] OPCODE_JUMP    = 4'h6;
    localparam logic [OPC_W-1:0] OPCODE_BRANCH  = 4'h7;
    localparam logic [OPC_W-1:0] OPCODE_PREFIX  = 4'hF;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } alu_fn_e;

    typedef enum logic [1:0] {
        BR_ALWAYS = 2'd0,
        BR_Z      = 2'd1,
        BR_NZ     = 2'd2,
        BR_C      = 2'd3
    } br_cond_e;

    typedef enum logic [0:0] {
        ST_NORMAL   = 1'b0,
        ST_PREFIXED = 1'b1
    } decode_state_e;

    typedef struct packed {
        logic                  reg_wr_en;
        logic                  mem_rd_en;
        logic                  mem_wr_en;
        logic                  jump_en;
        logic                  imm_sel;
        logic [REG_ADDR_W-1:0] reg_addr;
        alu_fn_e               alu_fn;
        br_cond_e              br_cond;
        logic                  pc_relative;
    } decoded_ctrl_t;

    localparam int CTRL_W = $bits(decoded_ctrl_t);

endpackage

// File: rtl/decode_skid_buffer.sv
// Two-entry in-order buffer. Entry 0 is the head and drives the outputs
// straight from registers; in_ready is a register so it never depends
// combinationally on out_ready.
module decode_skid_buffer
    import decoder_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_pop
);

    logic [W-1:0] r_ent0;
    logic [W-1:0] r_ent1;
    logic [1:0]   r_cnt;
    logic         r_ready;
    logic         r_valid;

    logic [W-1:0] w_ent0_nxt;
    logic [W-1:0] w_ent1_nxt;
    logic [1:0]   w_cnt_nxt;
    logic         w_push;
    logic         w_pop;

    assign w_push    = in_valid && r_ready && !flush;
    assign w_pop     = r_valid && out_ready;
    assign in_ready  = r_ready;
    assign out_valid = r_valid;
    assign out_data  = r_ent0;
    assign out_pop   = w_pop;

    // Next entry contents and occupancy for push, pop, both, or flush.
    always_comb begin
        w_ent0_nxt = r_ent0;
        w_ent1_nxt = r_ent1;
        w_cnt_nxt  = r_cnt;
        if (flush) begin
            w_cnt_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        w_ent0_nxt = in_data;
                    end else begin
                        w_ent1_nxt = in_data;
                    end
                    w_cnt_nxt = r_cnt + 2'd1;
                end
                2'b01: begin
                    w_ent0_nxt = r_ent1;
                    w_cnt_nxt  = r_cnt - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the older entry moves up first.
                    if (r_cnt == 2'd1) begin
                        w_ent0_nxt = in_data;
                    end else begin
                        w_ent0_nxt = r_ent1;
                        w_ent1_nxt = in_data;
                    end
                end
                default: begin
                    w_cnt_nxt = r_cnt;
                end
            endcase
        end
    end

    // Buffer storage, occupancy and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_cnt   <= 2'd0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_ent0  <= w_ent0_nxt;
            r_ent1  <= w_ent1_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_cnt_nxt < 2'd2);
            r_valid <= (w_cnt_nxt != 2'd0);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes accepted fetch words, handles the
// immediate-extension prefix, and queues results in a 2-entry skid buffer.
module decode_stage
    import decoder_pkg::*;
#(
    parameter int INST_W         = 16,
    parameter int DATA_W         = 8,
    parameter int I_ADDR_W       = 12,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int EXT_DATA_W     = 16,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_valid,
    input  logic [INST_W-1:0]     fetch_instruction,
    output logic                  fetch_ready,
    input  logic                  flush,
    output logic                  dec_valid,
    input  logic                  dec_ready,
    output decoded_ctrl_t         dec_ctrl,
    output logic [EXT_DATA_W-1:0] dec_imm,
    output logic [I_ADDR_W-1:0]   dec_addr_imm,
    output logic                  dec_illegal,
    output logic [CNT_W-1:0]      decode_count
);

    localparam int PL_W  = INST_W - OPC_W;
    localparam int PAY_W = CTRL_W + EXT_DATA_W + I_ADDR_W + 1;

    decode_state_e        r_state;
    decode_state_e        w_state_nxt;
    logic [PL_W-1:0]      r_payload;
    logic [PL_W-1:0]      w_payload_nxt;
    logic [CNT_W-1:0]     r_decode_count;

    logic [OPC_W-1:0]      w_opcode;
    logic [PL_W-1:0]       w_field;
    logic [DATA_W-1:0]     w_data_imm;
    logic [REG_ADDR_W-1:0] w_reg;
    logic                  w_is_prefix;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_fetch_ready;
    logic                  w_pop;

    decoded_ctrl_t         w_ctrl;
    logic                  w_illegal;
    logic [EXT_DATA_W-1:0] w_ext_imm;
    logic [I_ADDR_W-1:0]   w_addr_imm;
    logic [PAY_W-1:0]      w_in_data;
    logic [PAY_W-1:0]      w_head;

    assign w_opcode    = fetch_instruction[INST_W-1 -: OPC_W];
    assign w_field     = fetch_instruction[PL_W-1:0];
    assign w_data_imm  = fetch_instruction[DATA_W-1:0];
    assign w_reg       = REG_ADDR_W'(fetch_instruction[PL_W-1 -: REG_ADDR_WIDTH]);
    assign w_addr_imm  = I_ADDR_W'(w_field);
    assign w_is_prefix = (w_opcode == OPCODE_PREFIX);
    assign w_accept    = fetch_valid && w_fetch_ready && !flush;
    assign w_push      = w_accept && !w_is_prefix;

    // Opcode decode into the control bundle; unknown encodings are illegal
    // with every write, memory and jump enable held low.
    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPCODE_NOP: begin
                w_ctrl = '0;
            end
            OPCODE_ALU_REG: begin
                if (fetch_instruction[3]) begin
                    w_illegal = 1'b1;
                end else begin
                    w_ctrl.reg_wr_en = 1'b1;
                    w_ctrl.reg_addr  = w_reg;
                    w_ctrl.alu_fn    = alu_fn_e'(fetch_instruction[2:0]);
                end
            end
            OPCODE_ALU_IMM: begin
                w_ctrl.reg_wr_en = 1'b1;
                w_ctrl.imm_sel   = 1'b1;
                w_ctrl.reg_addr  = w_reg;
                w_ctrl.alu_fn    = ALU_ADD;
            end
            OPCODE_SET: begin
                w_ctrl.reg_wr_en = 1'b1;
                w_ctrl.imm_sel   = 1'b1;
                w_ctrl.reg_addr  = w_reg;
                w_ctrl.alu_fn    = ALU_PASS;
            end
            OPCODE_LOAD: begin
                w_ctrl.reg_wr_en = 1'b1;
                w_ctrl.mem_rd_en = 1'b1;
                w_ctrl.imm_sel   = 1'b1;
                w_ctrl.reg_addr  = w_reg;
            end
            OPCODE_STORE: begin
                w_ctrl.mem_wr_en = 1'b1;
                w_ctrl.imm_sel   = 1'b1;
                w_ctrl.reg_addr  = w_reg;
            end
            OPCODE_JUMP: begin
                w_ctrl.jump_en = 1'b1;
            end
            OPCODE_BRANCH: begin
                w_ctrl.jump_en     = 1'b1;
                w_ctrl.pc_relative = 1'b1;
                w_ctrl.br_cond     = br_cond_e'(fetch_instruction[PL_W-1 -: 2]);
            end
            OPCODE_PREFIX: begin
                // Never pushed; consumed by the prefix state machine.
                w_ctrl = '0;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Data immediate: zero-extended, or topped with the stored prefix payload.
    always_comb begin
        if (r_state == ST_PREFIXED) begin
            w_ext_imm = (EXT_DATA_W'(r_payload) << DATA_W) | EXT_DATA_W'(w_data_imm);
        end else begin
            w_ext_imm = EXT_DATA_W'(w_data_imm);
        end
    end

    // Prefix FSM next state: a prefix (re)loads the payload, any other
    // accepted word consumes it, flush drops it.
    always_comb begin
        w_state_nxt   = r_state;
        w_payload_nxt = r_payload;
        if (flush) begin
            w_state_nxt   = ST_NORMAL;
            w_payload_nxt = '0;
        end else if (w_accept) begin
            case (r_state)
                ST_NORMAL, ST_PREFIXED: begin
                    if (w_is_prefix) begin
                        w_state_nxt   = ST_PREFIXED;
                        w_payload_nxt = w_field;
                    end else begin
                        w_state_nxt = ST_NORMAL;
                    end
                end
                default: begin
                    w_state_nxt = ST_NORMAL;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Prefix FSM state and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_NORMAL;
            r_payload <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_payload <= w_payload_nxt;
        end
    end

    assign w_in_data = {w_ctrl, w_ext_imm, w_addr_imm, w_illegal};

    decode_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (w_push),
        .in_ready  (w_fetch_ready),
        .in_data   (w_in_data),
        .out_valid (dec_valid),
        .out_ready (dec_ready),
        .out_data  (w_head),
        .out_pop   (w_pop)
    );

    assign fetch_ready = w_fetch_ready;
    assign {dec_ctrl, dec_imm, dec_addr_imm, dec_illegal} = w_head;

    // Departure counter; wraps naturally and ignores flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_decode_count <= '0;
        end else if (w_pop) begin
            r_decode_count <= r_decode_count + CNT_W'(1'b1);
        end else begin
            r_decode_count <= r_decode_count;
        end
    end

    assign decode_count = r_decode_count;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have parameter INST_W, default 16, instruction width in bits.
REQ-002 The module SHALL have parameter DATA_W, default 8, base data immediate width.
REQ-003 The module SHALL have parameter I_ADDR_W, default 12, instruction address width.
REQ-004 The module SHALL have parameter REG_ADDR_WIDTH, default 4, register address width.
REQ-005 The module SHALL have parameter EXT_DATA_W, default 16, extended data immediate width; legal range DATA_W..DATA_W+INST_W-4.
REQ-006 The module SHALL have parameter CNT_W, default 16, retired-decode counter width.
REQ-007 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 The module SHALL have port fetch_valid, input, 1, fetch_instruction is valid.
REQ-010 The module SHALL have port fetch_instruction, input, INST_W, raw instruction word.
REQ-011 The module SHALL have port fetch_ready, output, 1, stage can accept a word this cycle.
REQ-012 The module SHALL have port flush, input, 1, discard all buffered and pending state.
REQ-013 The module SHALL have port dec_valid, output, 1, dec_ctrl and dec_imm are valid.
REQ-014 The module SHALL have port dec_ready, input, 1, downstream accepts this cycle.
REQ-015 The module SHALL have port dec_ctrl, output, decoded_ctrl_t, registered control bundle: enables, reg_addr, alu function, branch condition, pc_relative.
REQ-016 The module SHALL have port dec_imm, output, EXT_DATA_W, extended data immediate.
REQ-017 The module SHALL have port dec_addr_imm, output, I_ADDR_W, address immediate.
REQ-018 The module SHALL have port dec_illegal, output, 1, the output entry carries an undefined opcode/function.
REQ-019 The module SHALL have port decode_count, output, CNT_W, number of entries handed downstream.

Function
REQ-020 A word SHALL be accepted when fetch_valid && fetch_ready && !flush.
REQ-021 The word SHALL be decoded combinationally on accept, with the registered result at the buffer head; min latency accept->dec_valid = 1 cycle.
REQ-022 The stage SHALL hold a 2-entry skid buffer; fetch_ready = (occupancy < 2), registered, not combinationally dependent on dec_ready.
REQ-023 An entry SHALL leave when dec_valid && dec_ready; simultaneous accept and leave SHALL keep occupancy unchanged and preserve order.
REQ-024 dec_* outputs SHALL be stable while dec_valid && !dec_ready.
REQ-025 The FSM SHALL have states NORMAL and PREFIXED; accepting an OPCODE_PREFIX word in either state SHALL store payload bits [INST_W-5:0] and enter PREFIXED, producing no output entry.
REQ-026 A second prefix in PREFIXED SHALL overwrite the stored payload (last prefix wins).
REQ-027 In PREFIXED, the next accepted non-prefix word SHALL get dec_imm = {payload[EXT_DATA_W-DATA_W-1:0], data_imm} and return the FSM to NORMAL.
REQ-028 In NORMAL, dec_imm SHALL be data_imm zero-extended to EXT_DATA_W.
REQ-029 An undefined opcode SHALL produce an entry with dec_illegal=1 and all write/memory/jump enables 0.
REQ-030 flush SHALL empty the buffer, return the FSM to NORMAL and block any accept that cycle, effective after the edge; decode_count is unaffected.
REQ-031 decode_count SHALL increment by 1 per departure and wrap from 2^CNT_W-1 to 0.

Reset
REQ-032 On rst_n low, the buffer SHALL be emptied and the FSM set to NORMAL immediately; the payload, dec_ctrl, dec_imm, dec_addr_imm and decode_count SHALL be 0, and dec_valid and dec_illegal SHALL be 0.
REQ-033 fetch_ready SHALL be 0 during reset and 1 from the first clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-operation SHALL discard buffered entries and a pending prefix.

Structure
REQ-035 decoded_ctrl_t, OPCODE_PREFIX and the decode_state_e enum SHALL be defined in decoder_pkg.
REQ-036 The skid buffer SHALL be a sub-module, decode_skid_buffer, parametrised by payload width.

Verification
REQ-037 Reset, then a single ALU-immediate word with dec_ready=1 -> dec_valid is 1 exactly one cycle later, with the correct ctrl fields, and decode_count=1.
REQ-038 Prefix payload 0x0AB, then SET with data_imm 0xCD (EXT_DATA_W=16) -> one entry with dec_imm=0xABCD; the following SET 0x12 -> 0x0012.
REQ-039 dec_ready=0 with 3 words offered -> 2 accepted, then fetch_ready=0 and outputs stable; dec_ready=1 drains both in order.
REQ-040 Prefix then flush, then SET 0x05 -> dec_imm=0x0005 and buffer emptied.
REQ-041 decode_count preset to 0xFFFF via 65535 departures, then one more -> 0x0000.
REQ-042 Undefined opcode -> dec_illegal=1 with all enables 0; rst_n pulsed while the buffer is full -> dec_valid=0 immediately.
